// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronises and debounces an active-low KEY, producing a clean
// level, press/release pulses, a sticky pending flag for a slow consumer and a press tally.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n_i,
  input  logic       ack_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       pending_o,
  output logic [7:0] press_count_o
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             pending_q, pending_d;
  logic [7:0]       press_count_q, press_count_d;

  // Both flops reset to the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
    end
  end

  assign s = ~sync_q[1];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    // A new press beats an ack; an ack arriving while the press pulse is visible is ignored.
    pending_d     = press_d | (pending_q & ~(ack_i & ~press_q));
    press_count_d = press_count_q + {7'd0, press_d};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      level_q       <= 1'b0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      pending_q     <= 1'b0;
      press_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      level_q       <= level_d;
      press_q       <= press_d;
      release_q     <= release_d;
      pending_q     <= pending_d;
      press_count_q <= press_count_d;
    end
  end

  assign level_o       = level_q;
  assign press_o       = press_q;
  assign release_o     = release_q;
  assign pending_o     = pending_q;
  assign press_count_o = press_count_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random key/ack/reset
// traffic, all compared cycle by cycle against a run-length debounce model.
module tb_key_conditioner;

  localparam int unsigned D = 4;

  logic       clk;
  logic       reset;
  logic       key_n;
  logic       ack;
  logic       level_o, press_o, release_o, pending_o;
  logic [7:0] press_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  key_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n_i      (key_n),
    .ack_i        (ack),
    .level_o      (level_o),
    .press_o      (press_o),
    .release_o    (release_o),
    .pending_o    (pending_o),
    .press_count_o(press_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the button state flips once the synchronised input has disagreed
  // with it for D+1 consecutive clock edges; the synchroniser is a two-sample delay.
  logic       k1 = 1'b1, k2 = 1'b1;
  int         run = 0;
  logic       m_level = 1'b0, m_press = 1'b0, m_release = 1'b0, m_pending = 1'b0;
  logic [7:0] m_count = 8'd0;

  task automatic model_edge();
    logic s_m;
    logic prev_press;
    if (reset) begin
      k1 = 1'b1; k2 = 1'b1; run = 0;
      m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_pending = 1'b0; m_count = 8'd0;
      return;
    end
    s_m = ~k2;
    k2  = k1;
    k1  = key_n;
    prev_press = m_press;
    m_press    = 1'b0;
    m_release  = 1'b0;
    if (s_m != m_level) begin
      run++;
      if (run == D + 1) begin
        m_level = s_m;
        run     = 0;
        if (s_m) m_press = 1'b1;
        else     m_release = 1'b1;
      end
    end else begin
      run = 0;
    end
    if (m_press)                 m_pending = 1'b1;
    else if (ack && !prev_press) m_pending = 1'b0;
    m_count = m_count + {7'd0, m_press};
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("level",   level_o,   m_level);
    check("press",   press_o,   m_press);
    check("release", release_o, m_release);
    check("pending", pending_o, m_pending);
    check("count",   press_count_o, m_count);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic saw_press;
    reset = 1'b1; key_n = 1'b1; ack = 1'b0;

    // 1: reset held three cycles with the key released
    hold(3);
    check("t1_level", level_o, 0);
    check("t1_press", press_o, 0);
    check("t1_release", release_o, 0);
    check("t1_pending", pending_o, 0);
    check("t1_count", press_count_o, 0);
    reset = 1'b0;
    hold(4);

    // 3: three-cycle bounce never produces a press
    key_n = 1'b0;
    hold(3);
    key_n = 1'b1;
    saw_press = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      saw_press = saw_press | press_o;
    end
    check("t3_no_press", saw_press, 0);
    check("t3_level", level_o, 0);
    check("t3_count", press_count_o, 0);

    // 2: clean press, pulse lands after edge 2+D
    key_n = 1'b0;
    hold(6);
    check("t2_press_early", press_o, 0);
    cycle();
    check("t2_press", press_o, 1);
    check("t2_level", level_o, 1);
    check("t2_pending", pending_o, 1);
    check("t2_count", press_count_o, 1);
    cycle();
    check("t2_press_one_cycle", press_o, 0);
    hold(5);

    // 4: clean release, pending survives
    key_n = 1'b1;
    hold(6);
    check("t4_release_early", release_o, 0);
    cycle();
    check("t4_release", release_o, 1);
    check("t4_level", level_o, 0);
    check("t4_pending", pending_o, 1);
    cycle();
    check("t4_release_one_cycle", release_o, 0);
    hold(4);

    // 5: ack during the press cycle is ignored, ack on the next cycle clears
    key_n = 1'b0;
    hold(7);
    check("t5_press", press_o, 1);
    ack = 1'b1;
    cycle();
    check("t5_pending_held", pending_o, 1);
    check("t5_count", press_count_o, 2);
    cycle();
    check("t5_pending_cleared", pending_o, 0);
    ack = 1'b0;
    key_n = 1'b1;
    hold(10);

    // 6: reset in the middle of a press debounce, then a fresh full debounce
    key_n = 1'b0;
    hold(4);
    reset = 1'b1;
    cycle();
    check("t6_rst_level", level_o, 0);
    check("t6_rst_press", press_o, 0);
    check("t6_rst_count", press_count_o, 0);
    reset = 1'b0;
    hold(6);
    check("t6_press_early", press_o, 0);
    cycle();
    check("t6_press", press_o, 1);
    check("t6_count", press_count_o, 1);
    key_n = 1'b1;
    hold(8);

    // 6b: press tally wraps 255 -> 0
    for (int p = 0; p < 255; p++) begin
      if (p == 254) check("t6_count_255", press_count_o, 255);
      key_n = 1'b0;
      hold(8);
      key_n = 1'b1;
      hold(8);
    end
    check("t6_count_wrap", press_count_o, 0);

    // Random key bouncing, acks and occasional resets
    for (int r = 0; r < 400; r++) begin
      int len;
      key_n = 1'($urandom_range(0, 1));
      len   = $urandom_range(1, 9);
      for (int c = 0; c < len; c++) begin
        ack   = ($urandom_range(0, 3) == 0);
        reset = ($urandom_range(0, 149) == 0);
        cycle();
      end
    end
    reset = 1'b0;
    ack   = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
